// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Fetch, load/store and memory-macro signals of the shared RAM port.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int WD = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [WD-1:0] if_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [WD-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [WD-1:0] d_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [WD-1:0] mem_wdata;
    logic [WD-1:0] mem_rdata;

    logic          stall;
    logic [31:0]   perf_conflicts;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, stall, perf_conflicts
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, stall, perf_conflicts
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port RAM between fetch and load/store with
//               starvation-bounded data priority and one outstanding read.
//               Define ARB_PERF_CNT_EN to build the conflict counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int WD         = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input wire logic          clk,
    input wire logic          rst,
    mem_port_arbiter_if.slave bus
);
    localparam logic [2:0] c_LAT        = 3'(RD_LAT);
    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

    logic [2:0]    r_cnt;
    logic          r_owner;
    logic [3:0]    r_starve;

    logic          w_elig;
    logic          w_d_win;
    logic          w_if_win;
    logic          w_rd_gnt;
    logic          w_ret;
    logic [AW-1:0] w_addr;

    // cnt==1 is the return cycle, which may also launch the next access
    assign w_elig   = (r_cnt <= 3'd1);
    assign w_d_win  = w_elig & bus.d_req & ~(bus.if_req & (r_starve == c_STARVE_MAX));
    assign w_if_win = w_elig & bus.if_req & ~w_d_win;
    assign w_rd_gnt = w_if_win | (w_d_win & ~bus.d_we);
    assign w_ret    = (r_cnt == 3'd1);
    assign w_addr   = w_d_win ? bus.d_addr : (w_if_win ? bus.if_addr : {AW{1'b0}});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= 3'd0;
            r_owner  <= 1'b0;
            r_starve <= 4'd0;
        end else begin
            if (w_rd_gnt) begin
                r_cnt   <= c_LAT;
                r_owner <= w_d_win;
            end else if (r_cnt != 3'd0) begin
                r_cnt <= r_cnt - 3'd1;
            end

            if (w_if_win) begin
                r_starve <= 4'd0;
            end else if (w_elig && bus.if_req && w_d_win && (r_starve != c_STARVE_MAX)) begin
                r_starve <= r_starve + 4'd1;
            end
        end
    end

    assign bus.if_gnt    = w_if_win;
    assign bus.d_gnt     = w_d_win;
    assign bus.mem_en    = w_if_win | w_d_win;
    assign bus.mem_we    = w_d_win & bus.d_we;
    assign bus.mem_addr  = w_addr;
    assign bus.mem_wdata = (w_if_win | w_d_win) ? bus.d_wdata : {WD{1'b0}};

    assign bus.if_rvalid = w_ret & ~r_owner;
    assign bus.d_rvalid  = w_ret & r_owner;
    assign bus.if_rdata  = (w_ret & ~r_owner) ? bus.mem_rdata : {WD{1'b0}};
    assign bus.d_rdata   = (w_ret & r_owner) ? bus.mem_rdata : {WD{1'b0}};

    assign bus.stall = (bus.if_req & ~w_if_win) | (bus.d_req & ~w_d_win);

`ifdef ARB_PERF_CNT_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf <= 32'd0;
        end else if (w_elig && bus.if_req && bus.d_req) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign bus.perf_conflicts = r_perf;
`else
    assign bus.perf_conflicts = 32'd0;
`endif
endmodule
`default_nettype wire
